// File: rtl/regfile_wr_sched_if.sv
// regfile_wr_sched_if: writeback, long-latency result, decode-read and register-file write signals
interface regfile_wr_sched_if #(parameter int regSize = 4, parameter int dataSize = 16);
  logic                wbWr;
  logic [regSize-1:0]  wbDst;
  logic [dataSize-1:0] wbData;
  logic                wbWrR15;
  logic [dataSize-1:0] wbR15Data;
  logic                luValid;
  logic                luReady;
  logic [regSize-1:0]  luDst;
  logic [dataSize-1:0] luData;
  logic                luWrR15;
  logic [dataSize-1:0] luR15Data;
  logic [regSize-1:0]  rdA1;
  logic [regSize-1:0]  rdA2;
  logic                hazard;
  logic [1:0]          pendCnt;
  logic                wr;
  logic                wrR15;
  logic [regSize-1:0]  regDst;
  logic [dataSize-1:0] regDstData;
  logic [dataSize-1:0] regR15Data;
  modport master (
    output wbWr, wbDst, wbData, wbWrR15, wbR15Data, luValid, luDst, luData, luWrR15, luR15Data, rdA1, rdA2,
    input  luReady, hazard, pendCnt, wr, wrR15, regDst, regDstData, regR15Data
  );
  modport slave (
    input  wbWr, wbDst, wbData, wbWrR15, wbR15Data, luValid, luDst, luData, luWrR15, luR15Data, rdA1, rdA2,
    output luReady, hazard, pendCnt, wr, wrR15, regDst, regDstData, regR15Data
  );
endinterface

// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: merges pipeline writeback with a 2-deep queue of long-latency results onto the register file write ports
module regfile_wr_sched #(
  parameter int regSize  = 4,
  parameter int dataSize = 16
) (
  input logic               clk,
  input logic               rst,
  regfile_wr_sched_if.slave bus
);
  typedef struct packed {
    logic [regSize-1:0]  dst;
    logic [dataSize-1:0] data;
    logic                wr15;
    logic [dataSize-1:0] r15;
  } entry_t;
  typedef enum logic {ISSUE, SPLIT} state_t;
  entry_t              mem_q [2];
  entry_t              head;
  state_t              state_q, state_d;
  logic                rd_q, wr_q;
  logic [1:0]          cnt_q;
  logic                push, pop;
  logic                wr_c, w15_c;
  logic [regSize-1:0]  dst_c;
  logic [dataSize-1:0] dd_c, d15_c;
  function automatic logic hits(entry_t e, logic [regSize-1:0] a1, logic [regSize-1:0] a2);
    return e.dst == a1 || e.dst == a2 || (e.wr15 && (a1 == '0 || a2 == '0));
  endfunction
  assign head        = mem_q[rd_q];
  assign bus.luReady = !rst && cnt_q != 2'd2;
  assign push        = bus.luValid && bus.luReady;
  assign bus.pendCnt = cnt_q;
  assign bus.hazard  = !rst && ((cnt_q != 2'd0 && hits(mem_q[rd_q], bus.rdA1, bus.rdA2)) ||
                                (cnt_q == 2'd2 && hits(mem_q[~rd_q], bus.rdA1, bus.rdA2)));
  // A head writing both R0 and R15 needs two cycles on the shared register; R15 lands last.
  always_comb begin
    wr_c    = bus.wbWr;
    dst_c   = bus.wbWr ? bus.wbDst : '0;
    dd_c    = bus.wbWr ? bus.wbData : '0;
    w15_c   = bus.wbWrR15 && !(bus.wbWr && bus.wbDst == '0);
    d15_c   = w15_c ? bus.wbR15Data : '0;
    pop     = 1'b0;
    state_d = state_q;
    if (state_q == SPLIT) begin
      if (!bus.wbWrR15) begin
        w15_c   = 1'b1;
        d15_c   = head.r15;
        pop     = 1'b1;
        state_d = ISSUE;
      end
    end else if (cnt_q != 2'd0 && !bus.wbWr && !(head.wr15 && bus.wbWrR15)) begin
      wr_c  = 1'b1;
      dst_c = head.dst;
      dd_c  = head.data;
      if (head.wr15 && head.dst == '0) begin
        state_d = SPLIT;
      end else begin
        w15_c = w15_c || head.wr15;
        d15_c = head.wr15 ? head.r15 : d15_c;
        pop   = 1'b1;
      end
    end
    if (rst) begin
      wr_c    = 1'b0;
      dst_c   = '0;
      dd_c    = '0;
      w15_c   = 1'b0;
      d15_c   = '0;
      pop     = 1'b0;
      state_d = ISSUE;
    end
  end
  assign bus.wr         = wr_c;
  assign bus.regDst     = dst_c;
  assign bus.regDstData = dd_c;
  assign bus.wrR15      = w15_c;
  assign bus.regR15Data = d15_c;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ISSUE;
      cnt_q   <= 2'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_q + 2'(push) - 2'(pop);
      rd_q    <= rd_q ^ pop;
      wr_q    <= wr_q ^ push;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= '{dst: bus.luDst, data: bus.luData, wr15: bus.luWrR15, r15: bus.luR15Data};
  end
endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb_regfile_wr_sched: directed stimulus with a write-port scoreboard checked by an independent monitor
module tb_regfile_wr_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  typedef struct {
    logic        wr;
    logic [3:0]  dst;
    logic [15:0] dd;
    logic        w15;
    logic [15:0] d15;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  regfile_wr_sched_if bus ();
  regfile_wr_sched #(.regSize(4), .dataSize(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic samp;
    @(negedge clk);
  endtask
  task automatic idle;
    bus.wbWr = 0; bus.wbDst = 0; bus.wbData = 0; bus.wbWrR15 = 0; bus.wbR15Data = 0;
    bus.luValid = 0; bus.luDst = 0; bus.luData = 0; bus.luWrR15 = 0; bus.luR15Data = 0;
    bus.rdA1 = 4'd15; bus.rdA2 = 4'd15;
  endtask
  task automatic expw(input logic wr, input logic [3:0] dst, input logic [15:0] dd,
                      input logic w15, input logic [15:0] d15);
    exp_t e;
    e.wr = wr; e.dst = dst; e.dd = dd; e.w15 = w15; e.d15 = d15;
    sbq.push_back(e);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic lu(input logic [3:0] dst, input logic [15:0] d, input logic w15, input logic [15:0] r15);
    bus.luValid = 1; bus.luDst = dst; bus.luData = d; bus.luWrR15 = w15; bus.luR15Data = r15;
  endtask
  always @(negedge clk) begin
    if (bus.wr || bus.wrR15) begin
      n_chk++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: wr=%b dst=%0h dd=%h wrR15=%b r15=%h at %0t",
                 bus.wr, bus.regDst, bus.regDstData, bus.wrR15, bus.regR15Data, $time);
      end else begin
        mon_e = sbq.pop_front();
        if ({bus.wr, bus.regDst, bus.regDstData, bus.wrR15, bus.regR15Data} !==
            {mon_e.wr, mon_e.dst, mon_e.dd, mon_e.w15, mon_e.d15}) begin
          n_fail++;
          $display("FAIL write_port: got wr=%b dst=%0h dd=%h wrR15=%b r15=%h expected wr=%b dst=%0h dd=%h wrR15=%b r15=%h at %0t",
                   bus.wr, bus.regDst, bus.regDstData, bus.wrR15, bus.regR15Data,
                   mon_e.wr, mon_e.dst, mon_e.dd, mon_e.w15, mon_e.d15, $time);
        end
      end
    end
  end
  initial begin
    idle();
    tick(); tick();
    samp();
    chk("rst_pendCnt", 32'(bus.pendCnt), 0);
    chk("rst_luReady", 32'(bus.luReady), 0);
    chk("rst_wr", 32'({bus.wr, bus.wrR15}), 0);
    chk("rst_hazard", 32'(bus.hazard), 0);
    // single lu result issues the cycle after its push
    tick(); rst = 0;
    lu(4'd3, 16'h1234, 0, 16'h0);
    expw(1, 4'd3, 16'h1234, 0, 16'h0);
    samp();
    chk("t16_luReady", 32'(bus.luReady), 1);
    chk("t16_no_bypass", 32'(bus.wr), 0);
    tick(); idle();
    samp();
    chk("t16_pend1", 32'(bus.pendCnt), 1);
    chk("t16_wr", 32'(bus.wr), 1);
    tick();
    samp();
    chk("t16_pend0", 32'(bus.pendCnt), 0);
    // pipeline writes hold off two queued results
    for (int i = 0; i < 4; i++) begin
      idle();
      bus.wbWr = 1; bus.wbDst = 4'd9; bus.wbData = 16'h0909;
      expw(1, 4'd9, 16'h0909, 0, 16'h0);
      if (i == 0) lu(4'd5, 16'hAAAA, 0, 16'h0);
      if (i == 1) lu(4'd6, 16'hBBBB, 0, 16'h0);
      if (i == 2) begin
        bus.rdA1 = 4'd6;
        samp();
        chk("t17_pendCnt", 32'(bus.pendCnt), 2);
        chk("t17_luReady", 32'(bus.luReady), 0);
        chk("t17_hazard6", 32'(bus.hazard), 1);
        bus.rdA1 = 4'd7; bus.rdA2 = 4'd8;
        #1;
        chk("t17_no_hazard", 32'(bus.hazard), 0);
      end
      tick();
    end
    idle();
    expw(1, 4'd5, 16'hAAAA, 0, 16'h0);
    expw(1, 4'd6, 16'hBBBB, 0, 16'h0);
    samp();
    chk("t17_first_dst", 32'(bus.regDst), 5);
    tick();
    samp();
    chk("t17_second_dst", 32'(bus.regDst), 6);
    tick();
    samp();
    chk("t17_drained", 32'(bus.pendCnt), 0);
    // R15-writing head waits for a free R15 port, then writes both together
    idle();
    lu(4'd2, 16'h2222, 1, 16'h7777);
    bus.wbWrR15 = 1; bus.wbR15Data = 16'h3333;
    expw(0, 4'd0, 16'h0, 1, 16'h3333);
    tick();
    idle();
    bus.wbWrR15 = 1; bus.wbR15Data = 16'h3333;
    expw(0, 4'd0, 16'h0, 1, 16'h3333);
    bus.rdA1 = 4'd0;
    samp();
    chk("t18_blocked", 32'(bus.wr), 0);
    chk("t18_hazard_r0", 32'(bus.hazard), 1);
    tick();
    idle();
    expw(1, 4'd2, 16'h2222, 1, 16'h7777);
    samp();
    chk("t18_both", 32'({bus.wr, bus.wrR15}), 3);
    tick();
    // R0 head with R15 write splits over two cycles
    idle();
    lu(4'd0, 16'hAAAA, 1, 16'h5555);
    tick();
    idle();
    expw(1, 4'd0, 16'hAAAA, 0, 16'h0);
    expw(0, 4'd0, 16'h0, 1, 16'h5555);
    samp();
    chk("t19_n_wrR15", 32'(bus.wrR15), 0);
    chk("t19_n_pend", 32'(bus.pendCnt), 1);
    tick();
    samp();
    chk("t19_n1_wr", 32'(bus.wr), 0);
    chk("t19_n1_pend", 32'(bus.pendCnt), 1);
    tick();
    samp();
    chk("t19_n2_pend", 32'(bus.pendCnt), 0);
    // pipeline R0 write with R15 request drops the R15 data
    idle();
    bus.wbWr = 1; bus.wbDst = 0; bus.wbData = 16'h1111; bus.wbWrR15 = 1; bus.wbR15Data = 16'h2222;
    expw(1, 4'd0, 16'h1111, 0, 16'h0);
    tick();
    // reset mid-SPLIT with a full queue
    idle();
    lu(4'd0, 16'h0101, 1, 16'h0202);
    tick();
    idle();
    lu(4'd4, 16'h0404, 0, 16'h0);
    expw(1, 4'd0, 16'h0101, 0, 16'h0);
    tick();
    idle();
    rst = 1;
    samp();
    chk("t21_pre_pend", 32'(bus.pendCnt), 2);
    chk("t21_pre_ready", 32'(bus.luReady), 0);
    tick();
    samp();
    chk("t21_pend", 32'(bus.pendCnt), 0);
    chk("t21_wr", 32'({bus.wr, bus.wrR15}), 0);
    chk("t21_ready", 32'(bus.luReady), 0);
    tick();
    rst = 0;
    samp();
    chk("t21_release_ready", 32'(bus.luReady), 1);
    chk("t21_release_wr", 32'({bus.wr, bus.wrR15}), 0);
    tick(); tick();
    samp();
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
